modbus_tx_framer: RTL and testbench

Sequences one Modbus RTU transmit frame onto the RS-485 UART path. Passes N payload bytes from the upstream byte source to the UART transmitter and updates the Modbus CRC-16 on each byte accepted. Appends the CRC low byte, then the high byte. Drives the RS-485 driver-enable from frame start until the line has drained plus a guard time.

---
 rtl/modbus_pkg.sv | 35 +++
 rtl/modbus_crc_accum.sv | 35 +++
 rtl/modbus_tx_framer.sv | 137 +++++++++++++
 tb/tb_modbus_tx_framer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modbus_pkg.sv
// ============================================================================
// Module   : modbus_pkg
// Brief    : Shared Modbus RTU framing types, CRC-16 constants and byte update.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package modbus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAYLOAD = 3'd1,
    CRC_LO  = 3'd2,
    CRC_HI  = 3'd3,
    DRAIN   = 3'd4,
    HOLD    = 3'd5
  } state_t;

  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  // Eight serial steps of the reflected CRC collapsed into one call.
  function automatic logic [15:0] crc16_modbus_byte(input logic [15:0] crc,
                                                    input logic [7:0]  data);
    logic [15:0] w_c;
    w_c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ CRC16_POLY_REFL) : (w_c >> 1);
    end
    return w_c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/modbus_crc_accum.sv
// ============================================================================
// Module   : modbus_crc_accum
// Brief    : Registered Modbus CRC-16 accumulator with clear and byte enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module modbus_crc_accum
  import modbus_pkg::*;
(
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] r_crc;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= CRC16_INIT;
    end else if (clear) begin
      r_crc <= CRC16_INIT;
    end else if (en) begin
      r_crc <= crc16_modbus_byte(r_crc, data);
    end
  end

  assign crc = r_crc;

endmodule

`default_nettype wire

// File: rtl/modbus_tx_framer.sv
// ============================================================================
// Module   : modbus_tx_framer
// Brief    : Modbus RTU transmit framer: payload pass-through, CRC append, DE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module modbus_tx_framer
  import modbus_pkg::*;
#(
  parameter int DE_HOLD = 16,
  parameter int LEN_W   = 8
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             tx_idle,
  output logic             de,
  output logic             busy,
  output logic             done,
  output logic [15:0]      crc_out
);

  localparam int c_hold_w = (DE_HOLD > 1) ? $clog2(DE_HOLD) : 1;
  localparam logic [c_hold_w-1:0] c_hold_init = c_hold_w'(DE_HOLD - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [LEN_W-1:0]    r_cnt;
  logic [c_hold_w-1:0] r_hold;
  logic [15:0]         r_crc_out;
  logic [15:0]         w_crc;
  logic                w_start_ok;
  logic                w_pay_hs;

  assign w_start_ok = (r_state == IDLE) && start && (len != '0);
  assign w_pay_hs   = (r_state == PAYLOAD) && s_valid && tx_ready;

  modbus_crc_accum u_crc (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clear   (w_start_ok),
    .en      (w_pay_hs),
    .data    (s_data),
    .crc     (w_crc)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    s_ready      = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_state_next = PAYLOAD;
      end
      PAYLOAD: begin
        tx_data  = s_data;
        tx_valid = s_valid;
        s_ready  = tx_ready;
        if (w_pay_hs && (r_cnt == LEN_W'(1))) w_state_next = CRC_LO;
      end
      CRC_LO: begin
        tx_data  = w_crc[7:0];
        tx_valid = 1'b1;
        if (tx_ready) w_state_next = CRC_HI;
      end
      CRC_HI: begin
        tx_data  = w_crc[15:8];
        tx_valid = 1'b1;
        if (tx_ready) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (tx_idle) w_state_next = HOLD;
      end
      HOLD: begin
        if (r_hold == '0) begin
          done         = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Exit on the last byte at count 1, so the counter never wraps below zero.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start_ok) begin
      r_cnt <= len;
    end else if (w_pay_hs) begin
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if ((r_state == DRAIN) && tx_idle) begin
      r_hold <= c_hold_init;
    end else if ((r_state == HOLD) && (r_hold != '0)) begin
      r_hold <= r_hold - c_hold_w'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc_out <= '0;
    end else if ((r_state == CRC_HI) && tx_ready) begin
      r_crc_out <= w_crc;
    end
  end

  assign crc_out = r_crc_out;
  assign busy    = (r_state != IDLE);
  assign de      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_modbus_tx_framer.sv
// ============================================================================
// Module   : tb_modbus_tx_framer
// Brief    : Directed self-checking bench for the Modbus RTU transmit framer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modbus_tx_framer;

  localparam int DE_HOLD = 16;
  localparam int LEN_W   = 8;

  logic             sys_clk  = 1'b0;
  logic             rst_n    = 1'b0;
  logic             start    = 1'b0;
  logic [LEN_W-1:0] len      = '0;
  logic [7:0]       s_data   = 8'h00;
  logic             s_valid  = 1'b0;
  logic             tx_ready = 1'b1;
  logic             tx_idle  = 1'b1;
  logic             s_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             de;
  logic             busy;
  logic             done;
  logic [15:0]      crc_out;

  modbus_tx_framer #(.DE_HOLD(DE_HOLD), .LEN_W(LEN_W)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_idle  (tx_idle),
    .de       (de),
    .busy     (busy),
    .done     (done),
    .crc_out  (crc_out)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Upstream source and UART ready model
  logic [7:0] src_q[$];
  logic       hs_src    = 1'b0;
  logic       rdy_mode  = 1'b0;
  logic       gap_mode  = 1'b0;

  always begin
    @(posedge sys_clk);
    #1;
    tx_ready = rdy_mode ? ((cyc % 3) == 0) : 1'b1;
    if (hs_src && (src_q.size() > 0)) void'(src_q.pop_front());
    if (src_q.size() == 0) begin
      s_valid = 1'b0;
    end else if (s_valid && !hs_src) begin
      s_valid = 1'b1;
    end else if (gap_mode && ((cyc % 2) == 1)) begin
      s_valid = 1'b0;
    end else begin
      s_valid = 1'b1;
      s_data  = src_q[0];
    end
  end

  // Wire monitor
  logic [7:0] wire_q[$];
  int         done_cnt   = 0;
  int         done_cyc   = 0;
  logic       de_at_done = 1'b0;
  int         stall_err  = 0;
  int         busy_seen  = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge sys_clk) begin
    hs_src = s_valid && s_ready;
    if (tx_valid && tx_ready) wire_q.push_back(tx_data);
    if (prev_stall && rst_n && !(tx_valid && (tx_data == prev_data))) stall_err++;
    prev_stall = tx_valid && !tx_ready && rst_n;
    prev_data  = tx_data;
    if (busy || de || done) busy_seen++;
    if (done) begin
      done_cnt++;
      done_cyc   = cyc;
      de_at_done = de;
    end
  end

  function automatic logic [63:0] wire_word();
    logic [63:0] w = '0;
    foreach (wire_q[i]) w = {w[55:0], wire_q[i]};
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic load_payload(input logic [47:0] p);
    for (int i = 0; i < 6; i++) src_q.push_back(p[47 - 8*i -: 8]);
  endtask

  int start_cyc = 0;
  task automatic do_start(input logic [LEN_W-1:0] l);
    start     = 1'b1;
    len       = l;
    start_cyc = cyc;
    tick(1);
    start = 1'b0;
    len   = '0;
  endtask

  task automatic wait_done(input string tag, input int limit, input int base);
    int n = 0;
    while ((done_cnt == base) && (n < limit)) begin
      tick(1);
      n++;
    end
    check({tag, "_done_count"}, done_cnt, base + 1);
  endtask

  task automatic wait_wire(input string tag, input int cnt, input int limit);
    int n = 0;
    while ((wire_q.size() < cnt) && (n < limit)) begin
      tick(1);
      n++;
    end
    check({tag, "_wire_progress"}, wire_q.size() >= cnt, 1);
  endtask

  localparam logic [47:0] PAY_A  = 48'h01_03_00_00_00_01;
  localparam logic [47:0] PAY_B  = 48'h01_03_00_00_00_0A;
  localparam logic [63:0] WIRE_A = 64'h01_03_00_00_00_01_84_0A;
  localparam logic [63:0] WIRE_B = 64'h01_03_00_00_00_0A_C5_CD;

  int de_low;
  int t_idle;

  initial begin
    // Reset state
    tick(3);
    check("rst_de", de, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_crc_out", crc_out, 0);
    rst_n = 1'b1;
    tick(2);

    // Frame A, no backpressure: latency and wire content
    load_payload(PAY_A);
    tick(1);
    wire_q.delete();
    do_start(6);
    wait_done("a", 100, 0);
    check("a_latency", done_cyc - start_cyc, 6 + 3 + DE_HOLD);
    check("a_de_at_done", de_at_done, 1);
    check("a_de_after", de, 0);
    check("a_busy_after", busy, 0);
    check("a_wire_count", wire_q.size(), 8);
    check("a_wire", wire_word(), WIRE_A);
    check("a_crc_out", crc_out, 16'h0A84);

    // Frame B with UART backpressure and a gapped source
    rdy_mode  = 1'b1;
    gap_mode  = 1'b1;
    load_payload(PAY_B);
    tick(1);
    wire_q.delete();
    stall_err = 0;
    do_start(6);
    wait_done("b", 400, 1);
    check("b_wire_count", wire_q.size(), 8);
    check("b_wire", wire_word(), WIRE_B);
    check("b_crc_out", crc_out, 16'hCDC5);
    check("b_stable", stall_err, 0);
    rdy_mode = 1'b0;
    gap_mode = 1'b0;
    tick(2);

    // len = 0 is ignored
    busy_seen = 0;
    do_start(0);
    tick(5);
    check("z_busy_seen", busy_seen, 0);
    check("z_done_count", done_cnt, 2);

    // Starts during PAYLOAD and HOLD ignored; long drain with tx_idle low
    load_payload(PAY_A);
    tick(1);
    wire_q.delete();
    tx_idle = 1'b0;
    do_start(6);
    wait_wire("c_pay", 2, 50);
    do_start(3);
    wait_wire("c_crc", 8, 100);
    de_low = 0;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (!de) de_low++;
    end
    check("c_drain_de", de_low, 0);
    check("c_drain_done", done_cnt, 2);
    tx_idle = 1'b1;
    t_idle  = cyc;
    tick(5);
    do_start(2);
    wait_done("c", 50, 2);
    check("c_hold_time", done_cyc - t_idle, DE_HOLD);
    check("c_de_at_done", de_at_done, 1);
    tick(30);
    check("c_single_done", done_cnt, 3);
    check("c_busy_after", busy, 0);
    check("c_wire_count", wire_q.size(), 8);
    check("c_wire", wire_word(), WIRE_A);
    check("c_crc_out", crc_out, 16'h0A84);

    // Asynchronous reset mid-payload, then a clean frame
    load_payload(PAY_A);
    tick(1);
    wire_q.delete();
    do_start(6);
    wait_wire("d_pay", 3, 50);
    @(negedge sys_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("d_rst_de", de, 0);
    check("d_rst_tx_valid", tx_valid, 0);
    check("d_rst_busy", busy, 0);
    check("d_rst_crc_out", crc_out, 0);
    src_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    load_payload(PAY_A);
    tick(1);
    wire_q.delete();
    do_start(6);
    wait_done("d", 100, 3);
    check("d_wire", wire_word(), WIRE_A);
    check("d_crc_out", crc_out, 16'h0A84);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
